serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Bit-serial addition controller that time-shares a single one-bit full-adder cell across a WIDTH-bit operation. It latches two operands and a carry-in on a start request, then feeds the full adder one bit per clock, LSB first, with the carry held in a flip-flop. After WIDTH cycles it presents the assembled sum and carry-out with a one-cycle done pulse. It sits between a requesting datapath and the gate-level full-adder cell, trading latency for area.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 2..32.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new addition; accepted only in IDLE.
- a  input  WIDTH  operand A; sampled on the accepting edge.
- b  input  WIDTH  operand B; sampled on the accepting edge.
- cin  input  1  carry-in; sampled on the accepting edge.
- busy  output  1  high while bits are being processed (RUN state).
- done  output  1  one-cycle pulse; sum and cout are valid.
- sum  output  WIDTH  result; held until the next accepted start.
- cout  output  1  final carry-out; held with sum.
- sub  input  1  present only with SERIAL_ADD_SUB_EN; see Configuration.

## Operation
- Reset values: busy=0, done=0, sum=0, cout=0, state=IDLE, bit counter=0, carry flip-flop=0, operand shift registers=0.
- The FSM has three states: IDLE, RUN and DONE.
- IDLE:
  - If start=1, latch a into shift register SA, b into SB, cin into the carry flip-flop, and clear the counter.
  - Clear sum, then go to RUN.
  - If start=0, stay in IDLE and hold sum and cout.
- RUN, once per cycle:
  - The full adder computes SA[0] + SB[0] + carry.
  - Its sum bit shifts into sum at the MSB, and sum shifts right by one.
  - SA and SB shift right by one, the carry flip-flop takes the full-adder carry, and the counter increments.
  - When the counter reaches WIDTH-1 and that bit has been processed, go to DONE. At that point sum holds all WIDTH bits in order, with bit 0 being the first one processed.
- DONE:
  - done=1 for exactly one cycle, and cout equals the carry flip-flop.
  - Go to IDLE.
- The result is (a + b + cin) mod 2^WIDTH. cout is bit WIDTH of the true sum.
- start is ignored in RUN and DONE. It is not queued: a requester must re-assert start in IDLE.
- Changes on a, b or cin after the accepting edge have no effect on the running operation.
- Reset asserted in any state (including mid-RUN) returns every register to its reset value at that edge. The abandoned operation produces no done pulse.
- Reset has priority over start when both are high on the same edge.

## Timing
- Call the edge where start is accepted in IDLE edge 0.
- busy goes high after edge 0 and stays high for exactly WIDTH cycles. It falls after edge WIDTH.
- done is high for the cycle following edge WIDTH, i.e. between edges WIDTH and WIDTH+1.
- Latency from the accepting edge to done is WIDTH+1 cycles, counting that edge.
- Throughput is one addition per WIDTH+2 cycles. The earliest next accept is edge WIDTH+2, with start held high from the DONE cycle.
- sum and cout are stable from the done cycle until the edge after the next accepted start. At that edge sum clears and cout holds its old value until DONE.
- The counter is $clog2(WIDTH) bits wide and never wraps within an operation.

## Configuration
- SERIAL_ADD_SUB_EN defined:
  - Adds the input port sub, sampled with the operands.
  - With sub=1, SB is loaded with ~b and the carry flip-flop with 1; cin is ignored. The result is a - b mod 2^WIDTH, and cout=1 means no borrow (a >= b unsigned).
  - With sub=0, behaviour is identical to the plain adder.
- SERIAL_ADD_SUB_EN undefined:
  - The sub port does not exist and the block only adds.

## Test plan
- WIDTH=8, a=0x35, b=0x4A, cin=0, start one cycle -> busy high 8 cycles; done pulses 9 cycles after the accept edge; sum=0x7F, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Hold start high continuously with alternating operand pairs:
  - Pairs accepted only in IDLE, one done per WIDTH+2 cycles.
  - Operand changes during RUN do not alter the result.
  - sum and cout stay held after done until the next accept.
- Assert rst for one cycle at the 4th RUN cycle of a=0xAA, b=0x55 -> all outputs 0 on the next cycle; no done pulse; a following start with a=0x01, b=0x02 gives sum=0x03, cout=0.
- With SERIAL_ADD_SUB_EN: sub=1, a=0x10, b=0x01 -> sum=0x0F, cout=1; sub=1, a=0x01, b=0x02 -> sum=0xFF, cout=0.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Bit-serial adder controller. A single one-bit full-adder cell is reused
//   for every bit of a WIDTH-bit addition, LSB first. The carry between bits
//   lives in a flip-flop. One addition takes WIDTH+2 cycles end to end.
//
//   Optional feature (compile-time macro):
//     SERIAL_ADD_SUB_EN - adds a 'sub' input. When high at the accepting
//                         edge, B is inverted and the carry is forced to 1,
//                         producing a - b with cout meaning "no borrow".

// One-bit full-adder cell shared across all bit positions.
module FullAddCell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_SUB_EN
  ,
  input  logic             sub
`endif
);

  // The bit counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
  localparam int CntWidth = $clog2(WIDTH);
  localparam logic [CntWidth-1:0] LastBit = CntWidth'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q;
  logic [WIDTH-1:0]    opA_q;
  logic [WIDTH-1:0]    opB_q;
  logic [WIDTH-1:0]    sum_q;
  logic                carry_q;
  logic [CntWidth-1:0] bitCnt_q;
  logic                busy_q;
  logic                done_q;
  logic                cout_q;

  logic [WIDTH-1:0]    loadB_d;
  logic                loadCarry_d;
  logic                faSum;
  logic                faCarry;

  // The shared cell always looks at the current LSBs and the carry flop.
  FullAddCell u_fullAdd (
    .a_i (opA_q[0]),
    .b_i (opB_q[0]),
    .c_i (carry_q),
    .s_o (faSum),
    .c_o (faCarry)
  );

  // Select what B and the carry flop are loaded with on an accepted start;
  // subtraction is two's complement: a + ~b + 1.
  always_comb begin
    loadB_d     = b;
    loadCarry_d = cin;
`ifdef SERIAL_ADD_SUB_EN
    if (sub) begin
      loadB_d     = ~b;
      loadCarry_d = 1'b1;
    end
`endif
  end

  // Control FSM and datapath registers; every output is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      opA_q    <= '0;
      opB_q    <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      bitCnt_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            opA_q    <= a;
            opB_q    <= loadB_d;
            carry_q  <= loadCarry_d;
            bitCnt_q <= '0;
            sum_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end

        RUN: begin
          sum_q   <= {faSum, sum_q[WIDTH-1:1]};
          opA_q   <= opA_q >> 1;
          opB_q   <= opB_q >> 1;
          carry_q <= faCarry;
          if (bitCnt_q == LastBit) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cout_q  <= faCarry;
            state_q <= DONE;
          end else begin
            bitCnt_q <= bitCnt_q + 1'b1;
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl
//   Self-checking bench for serial_add_ctrl (WIDTH=8). A behavioural model
//   tracks each accepted addition as a plain integer sum and a count of
//   clock edges since acceptance; outputs are compared on every negedge.
//   Build with SERIAL_ADD_SUB_EN to also exercise subtraction.

module tb_serial_add_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         subIn;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   int checks   = 0;
   int failures = 0;
   bit checkEn  = 1'b0;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
`ifdef SERIAL_ADD_SUB_EN
      ,
      .sub   (subIn)
`endif
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Full (W+1)-bit result of an operation as plain arithmetic.
   function automatic logic [W:0] opResult(input logic [W-1:0] aV, input logic [W-1:0] bV,
                                           input logic cV, input logic sV);
      if (sV)
         return {1'b0, aV} + {1'b0, ~bV} + (W+1)'(1);
      return {1'b0, aV} + {1'b0, bV} + {{W{1'b0}}, cV};
   endfunction

   // After k bits processed, the low k result bits sit at the top of sum.
   function automatic logic [W-1:0] partialSum(input logic [W:0] res, input int k);
      logic [63:0] low;
      low = 64'(res) & ((64'd1 << k) - 64'd1);
      return W'(low << (W - k));
   endfunction

   // Model state: whether an operation is in flight and how many edges
   // have passed since its accepting edge.
   bit           mActive = 1'b0;
   int           mK      = 0;
   logic [W:0]   mRes    = '0;
   logic [W-1:0] mSum    = '0;
   logic         mCout   = 1'b0;

   // Advance the model on every rising edge.
   always @(posedge clk) begin
      if (rst) begin
         mActive <= 1'b0;
         mK      <= 0;
         mSum    <= '0;
         mCout   <= 1'b0;
      end else if (!mActive) begin
         if (start) begin
            mActive <= 1'b1;
            mK      <= 0;
            mSum    <= '0;
            mRes    <= opResult(a, b, cin, subIn);
         end
      end else begin
         mK <= mK + 1;
         if (mK + 1 <= W) mSum <= partialSum(mRes, mK + 1);
         if (mK + 1 == W) mCout <= mRes[W];
         if (mK + 1 == W + 1) mActive <= 1'b0;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, got, exp, $time);
      end
   endtask

   // Compare DUT outputs against the model on every falling edge.
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("busy", 32'(busy), 32'(mActive && mK < W));
         checkOutput("done", 32'(done), 32'(mActive && mK == W));
         checkOutput("sum",  32'(sum),  32'(mSum));
         checkOutput("cout", 32'(cout), 32'(mCout));
      end
   end

   // Issue one operation from IDLE, scramble inputs after acceptance and
   // measure edges-to-done and busy cycles.
   task automatic applyStimulus(input logic [W-1:0] aV, input logic [W-1:0] bV,
                                input logic cV, input logic sV,
                                output int lat, output int busyCycles);
      @(posedge clk); #1;
      start = 1'b1; a = aV; b = bV; cin = cV; subIn = sV;
      @(posedge clk); #1;
      start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      lat = -1;
      busyCycles = 0;
      for (int i = 0; i < 40; i++) begin
         if (i > 0) @(posedge clk);
         @(negedge clk);
         if (busy === 1'b1) busyCycles++;
         if (done === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   int lat;
   int busyCycles;
   int doneCnt;

   initial begin
      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; subIn = 1'b0;
      @(posedge clk); #1;
      checkEn = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk); #1;
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_sum",  32'(sum),  32'd0);
      checkOutput("reset_cout", 32'(cout), 32'd0);

      applyStimulus(8'h35, 8'h4A, 1'b0, 1'b0, lat, busyCycles);
      checkOutput("lat_35_4A",  32'(lat), 32'd8);
      checkOutput("busy_35_4A", 32'(busyCycles), 32'd8);
      checkOutput("sum_35_4A",  32'(sum), 32'h7F);
      checkOutput("cout_35_4A", 32'(cout), 32'd0);
      repeat (5) @(negedge clk);
      checkOutput("hold_sum_7F", 32'(sum), 32'h7F);

      applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0, lat, busyCycles);
      checkOutput("sum_FF_01",  32'(sum), 32'h00);
      checkOutput("cout_FF_01", 32'(cout), 32'd1);

      applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b0, lat, busyCycles);
      checkOutput("sum_FF_FF_1",  32'(sum), 32'hFF);
      checkOutput("cout_FF_FF_1", 32'(cout), 32'd1);

      // Start held high: exactly one done per W+2 cycles.
      @(posedge clk); #1;
      start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
      doneCnt = 0;
      for (int i = 0; i < 10 * (W + 2); i++) begin
         @(posedge clk); #1;
         a = (i % 2 == 0) ? 8'hA5 : 8'h3C;
         b = (i % 2 == 0) ? 8'h5A : W'($urandom);
         cin = 1'($urandom);
         @(negedge clk);
         if (done === 1'b1) doneCnt++;
      end
      start = 1'b0;
      checkOutput("stream_dones", 32'(doneCnt), 32'd10);
      repeat (12) @(posedge clk);

      // Reset during the 4th RUN cycle abandons the operation.
      #1;
      start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk); #1;
      checkOutput("midrst_busy", 32'(busy), 32'd0);
      checkOutput("midrst_done", 32'(done), 32'd0);
      checkOutput("midrst_sum",  32'(sum),  32'd0);
      checkOutput("midrst_cout", 32'(cout), 32'd0);
      doneCnt = 0;
      repeat (12) begin
         @(negedge clk);
         if (done === 1'b1) doneCnt++;
      end
      checkOutput("midrst_no_done", 32'(doneCnt), 32'd0);
      applyStimulus(8'h01, 8'h02, 1'b0, 1'b0, lat, busyCycles);
      checkOutput("lat_01_02",  32'(lat), 32'd8);
      checkOutput("sum_01_02",  32'(sum), 32'h03);
      checkOutput("cout_01_02", 32'(cout), 32'd0);

`ifdef SERIAL_ADD_SUB_EN
      applyStimulus(8'h10, 8'h01, 1'b0, 1'b1, lat, busyCycles);
      checkOutput("sub_sum_10_01",  32'(sum), 32'h0F);
      checkOutput("sub_cout_10_01", 32'(cout), 32'd1);
      applyStimulus(8'h01, 8'h02, 1'b1, 1'b1, lat, busyCycles);
      checkOutput("sub_sum_01_02",  32'(sum), 32'hFF);
      checkOutput("sub_cout_01_02", 32'(cout), 32'd0);
      subIn = 1'b0;
`endif

      // Randomized traffic with occasional resets; the model checks it all.
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         start = ($urandom_range(0, 3) != 0);
         a     = W'($urandom);
         b     = W'($urandom);
         cin   = 1'($urandom_range(0, 1));
         rst   = ($urandom_range(0, 80) == 0);
`ifdef SERIAL_ADD_SUB_EN
         subIn = 1'($urandom_range(0, 1));
`endif
      end
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      repeat (12) @(posedge clk);
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
